npm_toggle_po_reset_arbiter: RTL and testbench



---
 rtl/npm_toggle_po_reset_arbiter_pkg.sv | 16 +
 rtl/npm_rr_pick.sv | 28 ++
 rtl/npm_toggle_po_reset_arbiter.sv | 125 ++++++++++++
 tb/tb_npm_toggle_po_reset_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npm_toggle_po_reset_arbiter_pkg.sv
// Shared encodings for primitive-sharing arbiters.
// The one-hot state constants are reused by sibling arbiters for other PHY primitives.
package npm_toggle_po_reset_arbiter_pkg;

    localparam int PRA_FSM_BIT = 6;

    typedef logic [PRA_FSM_BIT-1:0] pra_state_t;

    localparam logic [PRA_FSM_BIT-1:0] PRA_RESET = 6'b000001;
    localparam logic [PRA_FSM_BIT-1:0] PRA_IDLE  = 6'b000010;
    localparam logic [PRA_FSM_BIT-1:0] PRA_START = 6'b000100;
    localparam logic [PRA_FSM_BIT-1:0] PRA_WAIT  = 6'b001000;
    localparam logic [PRA_FSM_BIT-1:0] PRA_DONE  = 6'b010000;
    localparam logic [PRA_FSM_BIT-1:0] PRA_ERR   = 6'b100000;

endpackage

// File: rtl/npm_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from last+1 with wrap-around; returns a one-hot winner and valid.
module npm_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    int unsigned pos;

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        grant = '0;
        valid = |req;
        pos   = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            pos = (int'(last) + i) % NUM_REQ;
            if (req[pos]) begin
                grant = NUM_REQ'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/npm_toggle_po_reset_arbiter.sv
// Round-robin arbiter/sequencer sharing one PHY-output reset primitive
// between NUM_REQ requesters; every output is a register.
module npm_toggle_po_reset_arbiter
    import npm_toggle_po_reset_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMER_W = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   iSystemClock,
    input  logic                   iReset,
    input  logic [NUM_REQ-1:0]     iReq,
    output logic [NUM_REQ-1:0]     oGrant,
    output logic [NUM_REQ-1:0]     oDone,
    output logic                   oError,
    output logic                   oPMStart,
    input  logic                   iPMReady,
    input  logic                   iPMLastStep,
    output logic                   oBusy,
    output logic [PRA_FSM_BIT-1:0] oDbgState
);

    localparam int IDX_W = $clog2(NUM_REQ);

    pra_state_t             state_q, state_d;
    logic [NUM_REQ-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   error_q, error_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic [NUM_REQ-1:0]     pick_grant;
    logic                   pick_valid;

    npm_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (iReq),
        .last  (last_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        timer_d = timer_q;
        case (state_q)
            PRA_RESET: state_d = PRA_IDLE;
            PRA_IDLE: begin
                if (pick_valid && iPMReady) begin
                    owner_d = pick_grant;
                    state_d = PRA_START;
                end
            end
            PRA_START: begin
                timer_d = '0;
                state_d = PRA_WAIT;
            end
            PRA_WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                // Last-step takes precedence over a coincident timeout.
                if (iPMLastStep) begin
                    state_d = PRA_DONE;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    state_d = PRA_ERR;
                end
            end
            PRA_DONE, PRA_ERR: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (owner_q[i]) begin
                        last_d = IDX_W'(i);
                    end
                end
                state_d = PRA_IDLE;
            end
            default: state_d = PRA_RESET;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        busy_d  = (state_d != PRA_RESET) && (state_d != PRA_IDLE);
        grant_d = busy_d ? owner_d : '0;
        start_d = (state_d == PRA_START);
        done_d  = ((state_d == PRA_DONE) || (state_d == PRA_ERR)) ? owner_d : '0;
        error_d = (state_d == PRA_ERR);
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state_q <= PRA_RESET;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            timer_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            error_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            error_q <= error_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign oGrant    = grant_q;
    assign oDone     = done_q;
    assign oError    = error_q;
    assign oPMStart  = start_q;
    assign oBusy     = busy_q;
    assign oDbgState = state_q;

endmodule

// File: tb/tb_npm_toggle_po_reset_arbiter.sv
// Directed bench for the reset-primitive arbiter: grants and completions are
// queued at stimulus time and checked by an independent monitor.
module tb_npm_toggle_po_reset_arbiter;
    import npm_toggle_po_reset_arbiter_pkg::*;

    logic       clk;
    logic       iReset;
    logic [3:0] iReq;
    logic [3:0] oGrant;
    logic [3:0] oDone;
    logic       oError;
    logic       oPMStart;
    logic       iPMReady;
    logic       iPMLastStep;
    logic       oBusy;
    logic [PRA_FSM_BIT-1:0] oDbgState;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int pm_delay = 10;

    logic [3:0]  gnt_q[$];
    logic [12:0] exp_q[$];  // {done[3:0], error, latency[7:0]}

    npm_toggle_po_reset_arbiter #(
        .NUM_REQ (4),
        .TIMER_W (8),
        .TIMEOUT (64)
    ) dut (
        .iSystemClock (clk),
        .iReset       (iReset),
        .iReq         (iReq),
        .oGrant       (oGrant),
        .oDone        (oDone),
        .oError       (oError),
        .oPMStart     (oPMStart),
        .iPMReady     (iPMReady),
        .iPMLastStep  (iPMLastStep),
        .oBusy        (oBusy),
        .oDbgState    (oDbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // primitive model: last-step pm_delay cycles after start, 0 means never
    initial begin
        iPMLastStep = 1'b0;
        forever begin
            @(negedge clk);
            if (oPMStart && pm_delay != 0) begin
                int d;
                d = pm_delay;
                repeat (d) @(posedge clk);
                #1 iPMLastStep = 1'b1;
                @(posedge clk);
                #1 iPMLastStep = 1'b0;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (oPMStart) begin
            if (gnt_q.size() == 0) begin
                fail_now("unexpected_start", 32'(oGrant));
            end else begin
                logic [3:0] eg;
                eg = gnt_q.pop_front();
                check("grant_at_start", 32'(oGrant), 32'(eg));
                check("busy_at_start", 32'(oBusy), 32'd1);
            end
            start_cyc = cyc;
        end
        if (oDone != 4'b0 || oError) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_done", {27'b0, oError, oDone});
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                check("done_vec", 32'(oDone), 32'(e[12:9]));
                check("error_flag", 32'(oError), 32'(e[8]));
                check("done_latency", 32'(cyc - start_cyc), 32'(e[7:0]));
                check("grant_held", 32'(oGrant), 32'(e[12:9]));
            end
        end
    end

    // driver tasks
    task automatic wait_start(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!oPMStart && k < 200);
        if (!oPMStart) fail_now(name, 32'(k));
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (oDone == 4'b0 && k < 200);
        if (oDone == 4'b0) fail_now(name, 32'(k));
    endtask

    task automatic push_op(input logic [3:0] gnt, input logic err, input logic [7:0] lat);
        gnt_q.push_back(gnt);
        exp_q.push_back({gnt, err, lat});
    endtask

    task automatic finish_op(input string name);
        wait_done(name);
        @(posedge clk);
        #1 iReq = 4'b0;
        @(negedge clk);
        check("busy_after_done", 32'(oBusy), 32'd0);
        check("idle_after_done", 32'(oDbgState), 32'(PRA_IDLE));
    endtask

    task automatic do_op(input logic [3:0] req, input logic [3:0] gnt, input logic err,
                         input logic [7:0] lat, input int delay, input string name);
        pm_delay = delay;
        push_op(gnt, err, lat);
        iReq = req;
        finish_op(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rr_order [5];
        int starts;
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        iReset = 1'b1;
        iReq = 4'b0;
        iPMReady = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_grant", 32'(oGrant), 32'd0);
        check("reset_start", 32'(oPMStart), 32'd0);
        check("reset_busy", 32'(oBusy), 32'd0);
        check("reset_done_err", {27'b0, oError, oDone}, 32'd0);
        @(posedge clk);
        #1 iReset = 1'b0;
        @(negedge clk);
        check("state_reset", 32'(oDbgState), 32'(PRA_RESET));
        @(negedge clk);
        check("state_idle", 32'(oDbgState), 32'(PRA_IDLE));
        @(posedge clk);
        #1;

        // round-robin: all request, each drops its bit for one cycle after oDone
        pm_delay = 10;
        for (int k = 0; k < 5; k++) push_op(rr_order[k], 1'b0, 8'd11);
        iReq = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done("rr_done_timeout");
            @(posedge clk);
            #1 iReq = iReq & ~rr_order[k];
            if (k == 4) iReq = 4'b0;
            @(posedge clk);
            #1 if (k < 4) iReq = iReq | rr_order[k];
        end
        repeat (3) @(posedge clk);
        #1;

        // single request, 10-cycle primitive
        do_op(4'b0100, 4'b0100, 1'b0, 8'd11, 10, "single_done_timeout");
        // timeout: no last-step
        do_op(4'b1000, 4'b1000, 1'b1, 8'd65, 0, "timeout_done_timeout");
        // last-step coincident with timeout: DONE wins
        do_op(4'b0001, 4'b0001, 1'b0, 8'd65, 64, "tie_done_timeout");

        // not ready: request waits, grant the cycle after ready rises
        pm_delay = 10;
        iPMReady = 1'b0;
        iReq = 4'b0001;
        repeat (5) @(negedge clk);
        check("no_grant_not_ready", 32'(oGrant), 32'd0);
        check("not_busy_not_ready", 32'(oBusy), 32'd0);
        @(posedge clk);
        push_op(4'b0001, 1'b0, 8'd11);
        #1 iPMReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("start_after_ready", 32'(oPMStart), 32'd1);
        finish_op("ready_done_timeout");

        // request withdrawn during WAIT
        @(posedge clk);
        #1;
        push_op(4'b0010, 1'b0, 8'd11);
        iReq = 4'b0010;
        wait_start("withdraw_start_timeout");
        @(posedge clk);
        #1 iReq = 4'b0;
        wait_done("withdraw_done_timeout");
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (oPMStart) starts++;
        end
        check("no_restart", 32'(starts), 32'd0);

        // reset mid-WAIT, then requester 0 has priority again
        @(posedge clk);
        #1;
        pm_delay = 0;
        gnt_q.push_back(4'b1000);
        iReq = 4'b1000;
        wait_start("rst_start_timeout");
        repeat (3) @(posedge clk);
        #1 iReset = 1'b1;
        iReq = 4'b0;
        @(posedge clk);
        #1 iReset = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {20'b0, oBusy, oPMStart, oError, oGrant, oDone}, 32'd0);
        check("midrst_state", 32'(oDbgState), 32'(PRA_RESET));
        pm_delay = 10;
        push_op(4'b0001, 1'b0, 8'd11);
        iReq = 4'b1111;
        finish_op("rst_prio_done_timeout");

        repeat (5) @(negedge clk);
        check("grant_queue_empty", 32'(gnt_q.size()), 32'd0);
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
